// File: rtl/alarm_link_pkg.sv
// Shared definitions for the alarm-panel serial link initiator.
// Holds the FSM encodings, the frame length and the baud divider helper.
package alarm_link_pkg;

  // Initiator command/response states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Receive sampler phases
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2
  } rx_phase_e;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Clocks per serial bit, integer-truncated
  function automatic int bit_cycles(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/alarm_poll_initiator_rx.sv
// 8N1 receive sampler: 2-FF synchronizer, start-bit glitch check, bit sampling.
// Ports: clk_i, rst_i, rxd_i in; byte_done_o, byte_data_o, stop_ok_o, rx_active_o out.
module serial_rx_sampler
  import alarm_link_pkg::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       byte_done_o,
  output logic [7:0] byte_data_o,
  output logic       stop_ok_o,
  output logic       rx_active_o
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  rx_phase_e     phase_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic [7:0]    shift_q;
  logic          done_q;
  logic          stop_q;

  logic rx_s;
  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      phase_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      prev_q <= rx_s;
      done_q <= 1'b0;
      unique case (phase_q)
        RX_IDLE: begin
          if (prev_q && !rx_s) begin
            phase_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // Mid start bit: line back high means a glitch
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rx_s) begin
              phase_q <= RX_IDLE;
            end else begin
              phase_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (idx_q == 4'd8) begin
              // Stop sample; free for the next start edge
              done_q  <= 1'b1;
              stop_q  <= rx_s;
              phase_q <= RX_IDLE;
            end else begin
              shift_q <= {rx_s, shift_q[7:1]};
              idx_q   <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: phase_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_done_o = done_q;
  assign byte_data_o = shift_q;
  assign stop_ok_o   = stop_q;
  assign rx_active_o = (phase_q != RX_IDLE);

endmodule

// File: rtl/alarm_poll_initiator.sv
// Host-side initiator: sends one 8N1 command byte, then awaits one response.
// Ports: cmd_* in, rsp_*/rx_stray/busy out, TxD out, RxD in (async).
module alarm_poll_initiator
  import alarm_link_pkg::*;
#(
  parameter int CLK_FREQ       = 25000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       rsp_error,
  output logic       rx_stray,
  output logic       busy,
  output logic       TxD,
  input  logic       RxD
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int BW = $clog2(BIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BLAST = BW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic       byte_done;
  logic [7:0] byte_data;
  logic       stop_ok;
  logic       rx_active;

  serial_rx_sampler #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxd_i      (RxD),
    .byte_done_o(byte_done),
    .byte_data_o(byte_data),
    .stop_ok_o  (stop_ok),
    .rx_active_o(rx_active)
  );

  state_e                state_q;
  logic                  txd_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [BW-1:0]         bcnt_q;
  logic [3:0]            bidx_q;
  logic [TW-1:0]         tmo_q;
  logic                  pend_q;
  logic                  pend_ok_q;
  logic [7:0]            pend_data_q;
  logic [7:0]            rsp_data_q;
  logic                  rsp_valid_q;
  logic                  rsp_timeout_q;
  logic                  rsp_error_q;
  logic                  rx_stray_q;

  // A byte finishing on this very edge overrides an older stored result
  logic       fin_ok;
  logic [7:0] fin_data;
  assign fin_ok   = byte_done ? stop_ok : pend_ok_q;
  assign fin_data = byte_done ? byte_data : pend_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      txd_q         <= 1'b1;
      frame_q       <= '1;
      bcnt_q        <= '0;
      bidx_q        <= '0;
      tmo_q         <= '0;
      pend_q        <= 1'b0;
      pend_ok_q     <= 1'b0;
      pend_data_q   <= 8'h00;
      rsp_data_q    <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_error_q   <= 1'b0;
      rx_stray_q    <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_error_q   <= 1'b0;
      rx_stray_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (byte_done) begin
            rx_stray_q <= 1'b1;
          end
          if (cmd_valid) begin
            state_q <= ST_SEND;
            frame_q <= {1'b1, cmd_data, 1'b0};
            txd_q   <= 1'b0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            pend_q  <= 1'b0;
          end
        end
        ST_SEND: begin
          // Early answer: hold it until our frame is out
          if (byte_done) begin
            pend_q      <= 1'b1;
            pend_ok_q   <= stop_ok;
            pend_data_q <= byte_data;
          end
          if (bcnt_q == BLAST) begin
            bcnt_q <= '0;
            if (bidx_q == LAST_BIT) begin
              txd_q <= 1'b1;
              tmo_q <= '0;
              if (pend_q || byte_done) begin
                state_q <= ST_IDLE;
                pend_q  <= 1'b0;
                if (fin_ok) begin
                  rsp_data_q  <= fin_data;
                  rsp_valid_q <= 1'b1;
                end else begin
                  rsp_error_q <= 1'b1;
                end
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              bidx_q  <= bidx_q + 4'd1;
              frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
              txd_q   <= frame_q[1];
            end
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (byte_done) begin
            state_q <= ST_IDLE;
            if (stop_ok) begin
              rsp_data_q  <= byte_data;
              rsp_valid_q <= 1'b1;
            end else begin
              rsp_error_q <= 1'b1;
            end
          end else if (!rx_active) begin
            // Frozen while a response byte is in flight
            if (tmo_q == TLAST) begin
              state_q       <= ST_IDLE;
              rsp_timeout_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign TxD         = txd_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_error   = rsp_error_q;
  assign rx_stray    = rx_stray_q;

endmodule

// File: tb/tb_alarm_poll_initiator.sv
// Directed bench for alarm_poll_initiator at 16 clocks/bit, 400-cycle timeout.
// Each scenario task drives the link and compares against hand-derived values.
module tb_alarm_poll_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       rsp_error;
  logic       rx_stray;
  logic       busy;
  logic       TxD;
  logic       RxD;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int t0;
  int fe;
  int ea;
  int p_when;
  logic [2:0] p_kind;
  logic [7:0] p_data;
  logic       p_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alarm_poll_initiator #(
    .CLK_FREQ      (1600000),
    .BAUD          (100000),
    .TIMEOUT_CYCLES(400)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .rsp_error  (rsp_error),
    .rx_stray   (rx_stray),
    .busy       (busy),
    .TxD        (TxD),
    .RxD        (RxD)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the first sample after the transfer edge; t0 marks it
  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (16) @(negedge clk);
    end
    RxD = stop;
    repeat (16) @(negedge clk);
    RxD = 1'b1;
  endtask

  // Watches 160 cycles of TX frame; counts bit errors and early pulses
  task automatic tx_watch(input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    fe = 0;
    ea = 0;
    for (int n = 0; n < 160; n++) begin
      if ((n % 16 == 0 || n % 16 == 8 || n % 16 == 15) && TxD !== fr[n / 16])
        fe++;
      if (rsp_valid || rsp_timeout || rsp_error)
        ea++;
      tick();
    end
  endtask

  task automatic wait_pulse(input int budget);
    p_when = -1;
    p_kind = 3'b000;
    for (int k = 0; k < budget; k++) begin
      if (rsp_valid || rsp_timeout || rsp_error) begin
        p_when  = cyc - t0;
        p_kind  = {rsp_valid, rsp_timeout, rsp_error};
        p_data  = rsp_data;
        p_ready = cmd_ready;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    RxD = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({TxD, cmd_ready, busy} !== 3'b110)
      $display("FAIL reset_lines got %b exp 110", {TxD, cmd_ready, busy});
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_timeout, rsp_error, rx_stray} !== 4'b0000)
      $display("FAIL reset_pulses got %b exp 0000",
               {rsp_valid, rsp_timeout, rsp_error, rx_stray});
    else n_pass++;
    n_chk++;
    if (rsp_data !== 8'h00)
      $display("FAIL reset_data got %h exp 00", rsp_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_response();
    issue(8'hA5);
    n_chk++;
    if ({cmd_ready, busy, TxD} !== 3'b010)
      $display("FAIL send_start got %b exp 010", {cmd_ready, busy, TxD});
    else n_pass++;
    fork
      begin
        tx_watch(8'hA5);
        wait_pulse(600);
      end
      begin
        repeat (239) @(negedge clk);
        rx_drive(8'h3C, 1'b1);
      end
    join
    n_chk++;
    if (fe !== 0) $display("FAIL frame_a5 got %0d bit errors exp 0", fe);
    else n_pass++;
    n_chk++;
    if (p_kind !== 3'b100 || p_data !== 8'h3C)
      $display("FAIL resp_3c got kind %b data %h exp 100 3c", p_kind, p_data);
    else n_pass++;
    n_chk++;
    if (p_ready !== 1'b1)
      $display("FAIL resp_ready got %b exp 1", p_ready);
    else n_pass++;
  endtask

  task automatic test_timeout();
    issue(8'h01);
    tx_watch(8'h01);
    wait_pulse(600);
    n_chk++;
    if (fe !== 0) $display("FAIL frame_01 got %0d bit errors exp 0", fe);
    else n_pass++;
    n_chk++;
    if (p_kind !== 3'b010 || p_when !== 560)
      $display("FAIL timeout got kind %b at %0d exp 010 at 560", p_kind, p_when);
    else n_pass++;
    tick();
    n_chk++;
    if ({busy, cmd_ready} !== 2'b01)
      $display("FAIL timeout_idle got %b exp 01", {busy, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_early_response();
    issue(8'hC3);
    fork
      begin
        tx_watch(8'hC3);
        wait_pulse(50);
      end
      rx_drive(8'h96, 1'b1);
    join
    n_chk++;
    if (ea !== 0) $display("FAIL early_pulse got %0d exp 0", ea);
    else n_pass++;
    n_chk++;
    if (p_kind !== 3'b100 || p_when !== 160 || p_data !== 8'h96)
      $display("FAIL deferred got kind %b at %0d data %h exp 100 at 160 96",
               p_kind, p_when, p_data);
    else n_pass++;
  endtask

  task automatic test_midstop();
    issue(8'h3A);
    fork
      begin
        tx_watch(8'h3A);
        wait_pulse(600);
      end
      begin
        repeat (151) @(negedge clk);
        rx_drive(8'hFF, 1'b1);
      end
    join
    n_chk++;
    if (ea !== 0 || fe !== 0)
      $display("FAIL midstop_tx got early %0d err %0d exp 0 0", ea, fe);
    else n_pass++;
    n_chk++;
    if (p_kind !== 3'b100 || p_data !== 8'hFF || p_when <= 160)
      $display("FAIL midstop got kind %b data %h at %0d exp 100 ff after 160",
               p_kind, p_data, p_when);
    else n_pass++;
  endtask

  task automatic test_stop_error();
    issue(8'h7E);
    fork
      begin
        tx_watch(8'h7E);
        wait_pulse(600);
      end
      begin
        repeat (199) @(negedge clk);
        rx_drive(8'h12, 1'b0);
      end
    join
    n_chk++;
    if (p_kind !== 3'b001)
      $display("FAIL stop_err got kind %b exp 001", p_kind);
    else n_pass++;
    n_chk++;
    if (rsp_data !== 8'hFF)
      $display("FAIL err_data got %h exp ff", rsp_data);
    else n_pass++;
  endtask

  task automatic test_stray_and_glitch();
    int ns;
    int nv;
    int nb;
    ns = 0;
    nv = 0;
    nb = 0;
    fork
      rx_drive(8'h55, 1'b1);
      for (int k = 0; k < 200; k++) begin
        if (rx_stray) ns++;
        if (rsp_valid || rsp_error || rsp_timeout) nv++;
        if (busy) nb++;
        tick();
      end
    join
    n_chk++;
    if (ns !== 1 || nv !== 0 || nb !== 0)
      $display("FAIL stray got stray %0d rsp %0d busy %0d exp 1 0 0", ns, nv, nb);
    else n_pass++;
    ns = 0;
    @(negedge clk);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    for (int k = 0; k < 250; k++) begin
      if (rx_stray || rsp_valid || rsp_error || rsp_timeout) ns++;
      tick();
    end
    n_chk++;
    if (ns !== 0) $display("FAIL glitch got %0d pulses exp 0", ns);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    issue(8'hE7);
    repeat (72) tick();
    n_chk++;
    if (TxD !== 1'b0) $display("FAIL bit4 got %b exp 0", TxD);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_chk++;
    if ({TxD, cmd_ready, busy} !== 3'b110)
      $display("FAIL abort_lines got %b exp 110", {TxD, cmd_ready, busy});
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_timeout, rsp_error, rx_stray} !== 4'b0000)
      $display("FAIL abort_pulses got %b exp 0000",
               {rsp_valid, rsp_timeout, rsp_error, rx_stray});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    issue(8'h81);
    fork
      begin
        tx_watch(8'h81);
        wait_pulse(600);
      end
      begin
        repeat (191) @(negedge clk);
        rx_drive(8'h42, 1'b1);
      end
    join
    n_chk++;
    if (fe !== 0 || p_kind !== 3'b100 || p_data !== 8'h42)
      $display("FAIL after_reset got err %0d kind %b data %h exp 0 100 42",
               fe, p_kind, p_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_response();
    test_timeout();
    test_early_response();
    test_midstop();
    test_stop_error();
    test_stray_and_glitch();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
